bus_coherence_ctrl: RTL and testbench

Snooping MESI coherence controller between two dcaches and the single-ported RAM. It answers each dcache's miss and write-back requests, snoops the peer cache, and satisfies fills by cache-to-cache transfer (with RAM update) or RAM read. It is the responder for the dcache SNOOPY/REPLY/INV/SUPPLY states and sits inside the memory controller, after the icache/dcache arbiter.

---
 rtl/bus_coherence_ctrl_if.sv | 38 +++
 rtl/bus_coherence_ctrl.sv | 142 ++++++++++++++
 tb/tb_bus_coherence_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_coherence_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_coherence_ctrl_if - dcache/RAM signal bundle for the coherence controller, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bus_coherence_ctrl_if #(
   parameter int CPUS = 2
);
   logic [CPUS-1:0]        dREN;
   logic [CPUS-1:0]        dWEN;
   logic [CPUS-1:0][31:0]  daddr;
   logic [CPUS-1:0][31:0]  dstore;
   logic [CPUS-1:0]        ccwrite;
   logic [CPUS-1:0]        cctrans;
   logic [CPUS-1:0]        dwait;
   logic [CPUS-1:0][31:0]  dload;
   logic [CPUS-1:0]        ccwait;
   logic [CPUS-1:0]        ccinv;
   logic [CPUS-1:0][31:0]  ccsnoopaddr;
   logic                   ramREN;
   logic                   ramWEN;
   logic [31:0]            ramaddr;
   logic [31:0]            ramstore;
   logic [31:0]            ramload;
   logic [1:0]             ramstate;

   modport slave (
      input  dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

`default_nettype wire

// File: rtl/bus_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// bus_coherence_ctrl - snooping MESI fill/write-back controller for two dcaches, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_coherence_ctrl #(
   parameter int CPUS      = 2,
   parameter int BLK_WORDS = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   bus_coherence_ctrl_if.slave   bus
);

   localparam int         WCW        = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ARB    = 3'd1;
   localparam logic [2:0] SNOOP  = 3'd2;
   localparam logic [2:0] C2C    = 3'd3;
   localparam logic [2:0] RAM_LD = 3'd4;
   localparam logic [2:0] WB     = 3'd5;

   logic [2:0]      state;
   logic [2:0]      next_state;
   logic [WCW-1:0]  wcnt;
   logic            req;
   logic            last;
   logic            grant;
   logic            peer;
   logic            access;
   logic            last_word;
   logic [CPUS-1:0] req_v;

   assign req_v     = bus.dREN | bus.dWEN;
   assign peer      = ~req;
   assign access    = (bus.ramstate == RAM_ACCESS);
   assign last_word = (wcnt == WCW'(BLK_WORDS - 1));

   // Round-robin: on a tie the cache that was not granted last time wins.
   always_comb begin
      grant = req_v[1];
      if (&req_v) begin
         grant = ~last;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (|req_v) next_state = ARB;
         end
         ARB: begin
            if (!(|req_v))           next_state = IDLE;
            else if (bus.dWEN[grant]) next_state = WB;
            else                     next_state = SNOOP;
         end
         SNOOP: begin
            if (bus.cctrans[peer]) next_state = bus.ccwrite[peer] ? C2C : RAM_LD;
         end
         C2C, RAM_LD, WB: begin
            if (access && last_word) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         wcnt  <= '0;
         last  <= 1'b0;
         req   <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            ARB: begin
               if (|req_v) begin
                  req  <= grant;
                  last <= grant;
                  wcnt <= '0;
               end
            end
            C2C, RAM_LD, WB: begin
               if (access) wcnt <= wcnt + WCW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from state; dwait follows ramstate in the same cycle.
   always_comb begin
      for (int i = 0; i < CPUS; i++) begin
         bus.dwait[i]       = 1'b1;
         bus.dload[i]       = 32'h0;
         bus.ccwait[i]      = 1'b0;
         bus.ccinv[i]       = 1'b0;
         bus.ccsnoopaddr[i] = 32'h0;
      end
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = 32'h0;
      bus.ramstore = 32'h0;
      case (state)
         WB: begin
            bus.ramWEN     = 1'b1;
            bus.ramaddr    = bus.daddr[req];
            bus.ramstore   = bus.dstore[req];
            bus.dwait[req] = ~access;
         end
         SNOOP: begin
            bus.ccwait[peer]      = 1'b1;
            bus.ccsnoopaddr[peer] = bus.daddr[req];
            bus.ccinv[peer]       = bus.ccwrite[req];
         end
         C2C: begin
            bus.ccwait[peer]      = 1'b1;
            bus.ccsnoopaddr[peer] = bus.daddr[req];
            bus.ccinv[peer]       = bus.ccwrite[req];
            bus.ramWEN            = 1'b1;
            bus.ramaddr           = bus.daddr[peer];
            bus.ramstore          = bus.dstore[peer];
            bus.dload[req]        = bus.dstore[peer];
            bus.dwait[req]        = ~access;
            bus.dwait[peer]       = ~access;
         end
         RAM_LD: begin
            bus.ramREN     = 1'b1;
            bus.ramaddr    = bus.daddr[req];
            bus.dload[req] = bus.ramload;
            bus.dwait[req] = ~access;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_coherence_ctrl - directed self-checking bench for bus_coherence_ctrl, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_coherence_ctrl;

   logic CLK;
   logic nRST;
   int   checks;
   int   errors;
   int   wr_cnt;
   int   wr0;

   bus_coherence_ctrl_if #(.CPUS(2)) bus ();

   bus_coherence_ctrl #(.CPUS(2), .BLK_WORDS(2)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (nRST && bus.ramWEN && bus.ramstate == 2'd2) wr_cnt <= wr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.dREN     = '0;
      bus.dWEN     = '0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ccwrite  = '0;
      bus.cctrans  = '0;
      bus.ramload  = '0;
      bus.ramstate = 2'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      wr_cnt = 0;
      nRST   = 1'b0;
      clear_inputs();
      step();
      step();
      #1;
      check_eq("rst_dwait",  32'(bus.dwait),  32'h3);
      check_eq("rst_ramren", 32'(bus.ramREN), 32'h0);
      check_eq("rst_ramwen", 32'(bus.ramWEN), 32'h0);
      check_eq("rst_ccwait", 32'(bus.ccwait), 32'h0);
      check_eq("rst_dload0", bus.dload[0],    32'h0);
      check_eq("rst_ramaddr", bus.ramaddr,    32'h0);
      nRST = 1'b1;
      step();

      // Both caches request together right after reset: cache1 wins the tie.
      bus.dREN = 2'b11; bus.daddr[0] = 32'h400; bus.daddr[1] = 32'h500;
      step(); #1;
      check_eq("arb_dwait",  32'(bus.dwait),  32'h3);
      check_eq("arb_ccwait", 32'(bus.ccwait), 32'h0);
      step(); #1;
      check_eq("tie_snoop_c0", 32'(bus.ccwait),   32'h1);
      check_eq("tie_snaddr0",  bus.ccsnoopaddr[0], 32'h500);
      bus.cctrans[0] = 1'b1;
      step(); bus.cctrans = '0; bus.ramstate = 2'd2; bus.ramload = 32'h5555_0000; #1;
      check_eq("tie_ld1_addr0", bus.ramaddr,       32'h500);
      check_eq("tie_ld1_dwait", 32'(bus.dwait),    32'h1);
      check_eq("tie_ld1_dload", bus.dload[1],      32'h5555_0000);
      step(); bus.daddr[1] = 32'h504; bus.ramload = 32'h5555_0004; #1;
      check_eq("tie_ld1_addr1", bus.ramaddr,       32'h504);
      check_eq("tie_ld1_dwt1",  32'(bus.dwait),    32'h1);
      step(); bus.dREN[1] = 1'b0; bus.ramstate = 2'd0; #1;
      check_eq("tie_idle_dwait", 32'(bus.dwait),   32'h3);
      step();
      step(); #1;
      check_eq("tie_snoop_c1", 32'(bus.ccwait),    32'h2);
      check_eq("tie_snaddr1",  bus.ccsnoopaddr[1], 32'h400);
      bus.cctrans[1] = 1'b1;
      step(); bus.cctrans = '0; bus.ramstate = 2'd2; #1;
      check_eq("tie_ld0_addr", bus.ramaddr,        32'h400);
      check_eq("tie_ld0_dwait", 32'(bus.dwait),    32'h2);
      step(); bus.daddr[0] = 32'h404; #1;
      check_eq("tie_ld0_dwt1", 32'(bus.dwait),     32'h2);
      step(); clear_inputs(); #1;
      check_eq("tie_end_ren",  32'(bus.ramREN),    32'h0);

      // Cache0 read miss, peer does not hold M: fill from RAM.
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100;
      step();
      step(); #1;
      check_eq("rd_ccwait", 32'(bus.ccwait),       32'h2);
      check_eq("rd_ccinv",  32'(bus.ccinv),        32'h0);
      check_eq("rd_snaddr", bus.ccsnoopaddr[1],    32'h100);
      check_eq("rd_noren",  32'(bus.ramREN),       32'h0);
      bus.cctrans[1] = 1'b1;
      step(); bus.cctrans = '0; bus.ramstate = 2'd2; bus.ramload = 32'h1111_2222; #1;
      check_eq("rd_w0_ren",   32'(bus.ramREN),     32'h1);
      check_eq("rd_w0_addr",  bus.ramaddr,         32'h100);
      check_eq("rd_w0_dload", bus.dload[0],        32'h1111_2222);
      check_eq("rd_w0_dwait", 32'(bus.dwait),      32'h2);
      step(); bus.daddr[0] = 32'h104; bus.ramload = 32'h3333_4444; #1;
      check_eq("rd_w1_addr",  bus.ramaddr,         32'h104);
      check_eq("rd_w1_dload", bus.dload[0],        32'h3333_4444);
      check_eq("rd_w1_dwait", 32'(bus.dwait),      32'h2);
      step(); clear_inputs(); #1;
      check_eq("rd_end_dwait", 32'(bus.dwait),     32'h3);
      check_eq("rd_end_ren",   32'(bus.ramREN),    32'h0);

      // Cache1 write miss, cache0 holds M and supplies the block.
      bus.dREN[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h200;
      step();
      step(); #1;
      check_eq("c2c_ccwait", 32'(bus.ccwait),      32'h1);
      check_eq("c2c_ccinv",  32'(bus.ccinv),       32'h1);
      check_eq("c2c_snaddr", bus.ccsnoopaddr[0],   32'h200);
      bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1;
      step();
      bus.cctrans = '0; bus.ccwrite[0] = 1'b0; bus.dWEN[0] = 1'b1;
      bus.daddr[0] = 32'h200; bus.dstore[0] = 32'hDEAD_BEEF; bus.ramstate = 2'd2; #1;
      check_eq("c2c_w0_wen",   32'(bus.ramWEN),    32'h1);
      check_eq("c2c_w0_ren",   32'(bus.ramREN),    32'h0);
      check_eq("c2c_w0_addr",  bus.ramaddr,        32'h200);
      check_eq("c2c_w0_store", bus.ramstore,       32'hDEAD_BEEF);
      check_eq("c2c_w0_dload", bus.dload[1],       32'hDEAD_BEEF);
      check_eq("c2c_w0_dwait", 32'(bus.dwait),     32'h0);
      check_eq("c2c_w0_ccwt",  32'(bus.ccwait),    32'h1);
      step(); bus.daddr[0] = 32'h204; bus.dstore[0] = 32'hCAFE_F00D; #1;
      check_eq("c2c_w1_addr",  bus.ramaddr,        32'h204);
      check_eq("c2c_w1_dload", bus.dload[1],       32'hCAFE_F00D);
      check_eq("c2c_w1_dwait", 32'(bus.dwait),     32'h0);
      step(); clear_inputs(); #1;
      check_eq("c2c_end_ccwt", 32'(bus.ccwait),    32'h0);
      check_eq("c2c_end_wen",  32'(bus.ramWEN),    32'h0);
      check_eq("c2c_end_dwt",  32'(bus.dwait),     32'h3);

      // Cache0 write-back with RAM busy for three cycles.
      wr0 = wr_cnt;
      bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'hAAAA_0001; bus.ramstate = 2'd1;
      step(); #1;
      check_eq("wb_arb_wen", 32'(bus.ramWEN),      32'h0);
      step(); #1;
      check_eq("wb_busy_wen",  32'(bus.ramWEN),    32'h1);
      check_eq("wb_busy_addr", bus.ramaddr,        32'h300);
      check_eq("wb_busy1_dwt", 32'(bus.dwait),     32'h3);
      step(); #1;
      check_eq("wb_busy2_dwt", 32'(bus.dwait),     32'h3);
      step(); #1;
      check_eq("wb_busy3_dwt", 32'(bus.dwait),     32'h3);
      step(); bus.ramstate = 2'd2; #1;
      check_eq("wb_w0_dwait", 32'(bus.dwait),      32'h2);
      check_eq("wb_w0_store", bus.ramstore,        32'hAAAA_0001);
      step(); bus.daddr[0] = 32'h304; bus.dstore[0] = 32'hAAAA_0002; #1;
      check_eq("wb_w1_addr",  bus.ramaddr,         32'h304);
      check_eq("wb_w1_dwait", 32'(bus.dwait),      32'h2);
      step(); clear_inputs(); #1;
      check_eq("wb_end_wen",  32'(bus.ramWEN),     32'h0);
      check_eq("wb_writes",   32'(wr_cnt - wr0),   32'h2);

      // RAM ERROR during a fill is retried like BUSY.
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h600;
      step();
      step(); #1;
      check_eq("err_ccwait", 32'(bus.ccwait),      32'h2);
      bus.cctrans[1] = 1'b1;
      step(); bus.cctrans = '0; bus.ramstate = 2'd3; #1;
      check_eq("err1_ren",   32'(bus.ramREN),      32'h1);
      check_eq("err1_addr",  bus.ramaddr,          32'h600);
      check_eq("err1_dwait", 32'(bus.dwait),       32'h3);
      step(); #1;
      check_eq("err2_dwait", 32'(bus.dwait),       32'h3);
      step(); bus.ramstate = 2'd2; bus.ramload = 32'h6666_0000; #1;
      check_eq("err_w0_dwait", 32'(bus.dwait),     32'h2);
      check_eq("err_w0_dload", bus.dload[0],       32'h6666_0000);
      step(); bus.daddr[0] = 32'h604; bus.ramstate = 2'd3; #1;
      check_eq("err_w1_ren",   32'(bus.ramREN),    32'h1);
      check_eq("err_w1_busy",  32'(bus.dwait),     32'h3);
      step(); bus.ramstate = 2'd2; bus.ramload = 32'h6666_0004; #1;
      check_eq("err_w1_dwait", 32'(bus.dwait),     32'h2);
      check_eq("err_w1_dload", bus.dload[0],       32'h6666_0004);
      step(); clear_inputs(); #1;
      check_eq("err_end_ren",  32'(bus.ramREN),    32'h0);

      // Reset pulse in the middle of a cache-to-cache transfer.
      bus.dREN[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h700;
      step();
      step(); bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1;
      step();
      bus.cctrans = '0; bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h700;
      bus.dstore[0] = 32'h7777_7777; bus.ramstate = 2'd1; #1;
      check_eq("mid_c2c_wen", 32'(bus.ramWEN),     32'h1);
      nRST = 1'b0;
      step(); nRST = 1'b1; #1;
      check_eq("rst_c2c_wen",   32'(bus.ramWEN),   32'h0);
      check_eq("rst_c2c_ccwt",  32'(bus.ccwait),   32'h0);
      check_eq("rst_c2c_dwait", 32'(bus.dwait),    32'h3);
      check_eq("rst_c2c_addr",  bus.ramaddr,       32'h0);
      clear_inputs();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
